// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter in front of a single iomem-style slave.
// One transaction is outstanding at a time: IDLE grants a master and
// registers its request, BUSY holds it until the slave answers or the
// timeout expires, and RESP returns a one-cycle ready pulse to the owner.
module iomem_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        grant,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Last BUSY count at which a missing s_ready aborts the transaction.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] to_cnt;
  logic       last_grant;
  logic       pick_valid;
  logic       pick;
  logic       start;
  logic       finish_ok;
  logic       finish_to;

  // Round-robin choice among the masters requesting this cycle.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_valid = m0_valid | m1_valid;
    pick       = 1'b0;
    if (m0_valid && m1_valid) begin
      pick = ~last_grant;
    end else if (m1_valid) begin
      pick = 1'b1;
    end
  end

  // A slave response on the final timeout cycle counts as a normal completion.
  assign start     = (state == IDLE) && pick_valid;
  assign finish_ok = (state == BUSY) && s_ready;
  assign finish_to = (state == BUSY) && !s_ready && (to_cnt == TO_LAST);

  // Next-state selection for the IDLE -> BUSY -> RESP -> IDLE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (finish_ok || finish_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter: cleared on grant, counts BUSY cycles without s_ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt <= 8'd0;
    end else if (start) begin
      to_cnt <= 8'd0;
    end else if ((state == BUSY) && !s_ready) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Slave-side request registers and ownership tracking.
  // last_grant resets to 1 so master 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_valid    <= 1'b0;
      s_wstrb    <= 4'd0;
      s_addr     <= 32'd0;
      s_wdata    <= 32'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else if (start) begin
      s_valid    <= 1'b1;
      s_wstrb    <= pick ? m1_wstrb : m0_wstrb;
      s_addr     <= pick ? m1_addr  : m0_addr;
      s_wdata    <= pick ? m1_wdata : m0_wdata;
      grant      <= pick;
      last_grant <= pick;
    end else if (finish_ok || finish_to) begin
      s_valid    <= 1'b0;
    end
  end

  // Master-side response: read data capture and one-cycle ready/error pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= 32'd0;
      m1_rdata    <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      timeout_err <= 1'b0;
      if (finish_ok || finish_to) begin
        if (grant) begin
          m1_ready <= 1'b1;
          m1_rdata <= finish_ok ? s_rdata : ERR_DATA;
        end else begin
          m0_ready <= 1'b1;
          m0_rdata <= finish_ok ? s_rdata : ERR_DATA;
        end
        timeout_err <= finish_to;
      end
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter (TIMEOUT = 4): a table of single
// transactions against a programmable-latency slave model, plus hand-written
// sequences for contention, stray s_ready, dropped requests and mid-BUSY reset.
module tb_iomem_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_wstrb = 4'd0, m1_wstrb = 4'd0;
  logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0, m0_wdata = 32'd0, m1_wdata = 32'd0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant, timeout_err;

  iomem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave model: raises s_ready in s_valid cycle number slave_delay (0-based).
  int          slave_delay = 0;
  int          scnt = 0;
  logic [31:0] slave_data = 32'd0;
  logic        model_ready = 1'b0;
  logic        stray_ready = 1'b0;
  assign s_ready = model_ready | stray_ready;
  assign s_rdata = slave_data;

  always @(posedge clk) begin
    #1;
    if (s_valid) begin
      model_ready = (scnt == slave_delay);
      scnt++;
    end else begin
      model_ready = 1'b0;
      scnt = 0;
    end
  end

  typedef struct {
    logic        mst;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          delay;
    int          exp_lat;
    int          exp_svc;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic        mst;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  logic [31:0] rd_model[2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic flag_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no ready within cycle budget", name);
  endtask

  // Pop the scoreboard and compare against the ready pulse seen this cycle.
  task automatic check_response();
    exp_t e;
    logic other;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: ready pulse with no expected response");
      return;
    end
    e = sb.pop_front();
    other = ~e.mst;
    check("both_ready", 32'(m0_ready & m1_ready), 32'd0);
    check("owner", 32'(m1_ready), 32'(e.mst));
    check("rdata", e.mst ? m1_rdata : m0_rdata, e.rdata);
    check("timeout_err", 32'(timeout_err), 32'(e.to));
    rd_model[e.mst] = e.rdata;
    check("other_rdata_hold", other ? m1_rdata : m0_rdata, rd_model[other]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_s_wstrb"}, 32'(s_wstrb), 32'd0);
    check({tag, "_s_addr"}, s_addr, 32'd0);
    check({tag, "_s_wdata"}, s_wdata, 32'd0);
    check({tag, "_m0_ready"}, 32'(m0_ready), 32'd0);
    check({tag, "_m1_ready"}, 32'(m1_ready), 32'd0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    rd_model[0] = 32'd0;
    rd_model[1] = 32'd0;
  endtask

  // One master transaction; cycle 0 is the cycle its valid first appears.
  task automatic run_txn(input vec_t v);
    int          svc = 0;
    bit          first = 1'b1, stable = 1'b1, done = 1'b0;
    logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0;
    logic [3:0]  cap_wstrb = 4'd0;
    @(posedge clk); #1;
    slave_delay = v.delay;
    slave_data  = v.sdata;
    if (v.mst) begin
      m1_valid = 1'b1; m1_wstrb = v.wstrb; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_valid = 1'b1; m0_wstrb = v.wstrb; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    sb.push_back('{mst: v.mst, rdata: v.exp_rdata, to: v.exp_to});
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (s_valid) begin
        svc++;
        if (first) begin
          check("sv_rise_cycle", 32'(c), 32'd1);
          check("s_addr", s_addr, v.addr);
          check("s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
          check("s_wdata", s_wdata, v.wdata);
          check("grant", 32'(grant), 32'(v.mst));
          cap_addr = s_addr; cap_wdata = s_wdata; cap_wstrb = s_wstrb;
          first = 1'b0;
        end else if (s_addr !== cap_addr || s_wdata !== cap_wdata || s_wstrb !== cap_wstrb) begin
          stable = 1'b0;
        end
      end
      if (m0_ready || m1_ready) begin
        check("latency", 32'(c), 32'(v.exp_lat));
        check_response();
        done = 1'b1;
      end
    end
    if (!done) begin
      flag_timeout("txn_ready");
      void'(sb.pop_front());
    end
    check("sv_cycles", 32'(svc), 32'(v.exp_svc));
    check("s_stable", 32'(stable), 32'd1);
    @(posedge clk); #1;
    if (v.mst) m1_valid = 1'b0; else m0_valid = 1'b0;
  endtask

  initial begin
    int rises, low, got, bad;
    bit prev, done;

    //          mst  wstrb  addr          wdata         sdata         dly lat svc exp_rdata     to
    vecs[0] = '{1'b0, 4'h0, 32'h0300_0004, 32'h0,        32'h0000_000A, 1,  3,  2, 32'h0000_000A, 1'b0};
    vecs[1] = '{1'b1, 4'h1, 32'h0300_0000, 32'h5,        32'h00C0_FFEE, 2,  4,  3, 32'h00C0_FFEE, 1'b0};
    vecs[2] = '{1'b0, 4'h0, 32'h0300_0008, 32'h0,        32'h1234_5678, 100, 5, 4, ERR,           1'b1};
    vecs[3] = '{1'b0, 4'h0, 32'h0300_000C, 32'h0,        32'hCAFE_F00D, 3,  5,  4, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 4'h0, 32'h0300_0010, 32'h0,        32'h0000_0077, 0,  2,  1, 32'h0000_0077, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 32'h0300_0014, 32'hDEAD_BEEF, 32'h55AA_55AA, 2, 4,  3, 32'h55AA_55AA, 1'b0};
    vecs[6] = '{1'b1, 4'h0, 32'h0300_0018, 32'h0,        32'h1111_1111, 4,  5,  4, ERR,           1'b1};
    vecs[7] = '{1'b0, 4'h3, 32'h0300_001C, 32'h0000_ABCD, 32'h0BAD_CAFE, 2, 4,  3, 32'h0BAD_CAFE, 1'b0};

    rd_model[0] = 32'd0;
    rd_model[1] = 32'd0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Contention right after reset: master 0 first, then master 1.
    do_reset();
    @(posedge clk); #1;
    slave_delay = 1;
    slave_data  = 32'hAAAA_0000;
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0040; m0_wdata = 32'h0;
    m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h0300_0044; m1_wdata = 32'h0;
    sb.push_back('{mst: 1'b0, rdata: 32'hAAAA_0000, to: 1'b0});
    sb.push_back('{mst: 1'b1, rdata: 32'hBBBB_0001, to: 1'b0});
    rises = 0; low = 0; got = 0; prev = 1'b0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      @(negedge clk);
      if (s_valid && !prev) begin
        check("rr_grant", 32'(grant), (rises == 0) ? 32'd0 : 32'd1);
        if (rises == 1) check("rr_gap", 32'(low >= 1), 32'd1);
        rises++;
      end
      if (!s_valid && rises > 0) low++;
      prev = s_valid;
      if (m0_ready || m1_ready) begin
        check("rr_ready_cycle", 32'(c), (got == 0) ? 32'd3 : 32'd7);
        check_response();
        got++;
        @(posedge clk); #1;
        if (got == 1) begin m0_valid = 1'b0; slave_data = 32'hBBBB_0001; end
        else m1_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (got < 2) begin
      flag_timeout("rr_ready");
      sb.delete();
    end
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Stray s_ready while idle must start nothing.
    stray_ready = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_valid || m0_ready || m1_ready || timeout_err) bad++;
    end
    check("stray_ready_ignored", 32'(bad), 32'd0);
    @(posedge clk); #1;
    stray_ready = 1'b0;

    // A master 1 request raised and dropped during master 0's BUSY is lost.
    @(posedge clk); #1;
    slave_delay = 2;
    slave_data  = 32'h0000_0042;
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0024; m0_wdata = 32'h0;
    sb.push_back('{mst: 1'b0, rdata: 32'h0000_0042, to: 1'b0});
    @(posedge clk); #1;
    m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h0300_0028; m1_wdata = 32'h0;
    @(posedge clk); #1;
    m1_valid = 1'b0;
    done = 1'b0;
    for (int c = 2; c < 40 && !done; c++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        check("drop_latency", 32'(c), 32'd4);
        check_response();
        done = 1'b1;
      end
    end
    if (!done) begin
      flag_timeout("drop_ready");
      sb.delete();
    end
    @(posedge clk); #1;
    m0_valid = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_valid || m1_ready || m0_ready) bad++;
    end
    check("dropped_req_silent", 32'(bad), 32'd0);

    // Reset while BUSY: outputs clear, no late ready, next request served.
    @(posedge clk); #1;
    slave_delay = 100;
    m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0030; m0_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", 32'(s_valid), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    m0_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    rd_model[0] = 32'd0;
    rd_model[1] = 32'd0;
    @(negedge clk);
    check_reset_outputs("midrst");
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (m0_ready || m1_ready || s_valid || timeout_err) bad++;
    end
    check("no_ready_after_reset", 32'(bad), 32'd0);
    run_txn(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 64, number of cycles s_valid stays high without s_ready before abort; legal range 2..255.
REQ-002: Parameter ERR_DATA, default 32'hFFFF_FFFF, read data returned to a master on timeout.
REQ-003: clk  input  1  single clock; all logic on its rising edge.
REQ-004: resetn  input  1  reset, synchronous, active-low.
REQ-005: m0_valid, m1_valid  input  1  master request, held high until that master's ready pulse.
REQ-006: m0_wstrb, m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-007: m0_addr, m1_addr, m0_wdata, m1_wdata  input  32  request address and write data.
REQ-008: m0_ready, m1_ready  output  1  one-cycle completion pulse to the owning master.
REQ-009: m0_rdata, m1_rdata  output  32  read data, valid in the ready cycle.
REQ-010: s_valid  output  1  request to shared iomem slave.
REQ-011: s_wstrb  output  4; s_addr, s_wdata  output  32  registered copy of the granted request.
REQ-012: s_ready  input  1  slave completion pulse; s_rdata  input  32  slave read data.
REQ-013: grant  output  1  index of the current or last owner.
REQ-014: timeout_err  output  1  one-cycle pulse when a transaction is aborted.

Function
REQ-015: The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-016: IDLE with any mN_valid high SHALL grant one master, latch its wstrb/addr/wdata into s_*, set grant, and move to BUSY.
- s_valid rises on the next cycle.
REQ-017: Arbitration SHALL be round-robin.
- Both valid: grant the master other than the last granted.
- One valid: grant it.
REQ-018: In BUSY, s_valid SHALL stay high and s_* stable until s_ready is sampled high or a timeout occurs.
REQ-019: On s_ready in BUSY, the block SHALL clear s_valid, register s_rdata into the owner's mN_rdata, and move to RESP.
- s_valid is clear in the cycle after s_ready.
REQ-020: In RESP, the owner's mN_ready SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
- The non-owner's ready stays 0.
REQ-021: A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle with s_ready low.
- Count reaching TIMEOUT-1 with s_ready low: clear s_valid, load ERR_DATA into owner's rdata, pulse timeout_err, go to RESP.
- s_valid is therefore high for exactly TIMEOUT cycles.
REQ-022: s_ready arriving on the final timeout cycle SHALL win: normal completion, no timeout_err.
REQ-023: s_ready sampled in IDLE or RESP SHALL be ignored.
REQ-024: A request whose valid drops before grant SHALL be dropped silently.
- Requests are sampled only in IDLE.
REQ-025: Latency SHALL be fixed.
- mN_valid rising in IDLE at cycle 0: s_valid at cycle 1.
- s_ready at cycle k: mN_ready at cycle k+1.
- Single-cycle slave (ready at cycle 2): mN_ready at cycle 3.
REQ-026: Only one transaction SHALL be outstanding at any time.
REQ-027: mN_rdata SHALL hold its last value outside ready cycles.

Reset
REQ-028: resetn low at any clock edge, including mid-transaction, SHALL force state IDLE and clear the timeout counter.
- Outputs cleared: s_valid, s_wstrb, s_addr, s_wdata, m0_ready, m1_ready, m0_rdata, m1_rdata, timeout_err, grant.
- Last-grant is set to 1, so master 0 wins the first contention.
REQ-029: A transaction interrupted by reset SHALL NOT produce a ready pulse after reset release.

Verification
REQ-030: m0 read addr 0x03000004, slave returns 0x0000000A with ready at cycle 2 -> m0_ready at cycle 3, m0_rdata=0x0000000A, m1_ready=0.
REQ-031: m0 and m1 valid at same cycle after reset, each slave ready after 1 cycle -> m0 served first, m1 next; grant sequence 0,1; s_valid low at least one cycle between them.
REQ-032: m1 write wstrb=4'h1, wdata=0x5 to 0x03000000 -> s_addr=0x03000000, s_wstrb=4'h1, s_wdata=0x5 stable while s_valid high; m1_ready one pulse.
REQ-033: TIMEOUT=4, slave never ready -> s_valid high 4 cycles, then m0_rdata=0xFFFFFFFF, m0_ready and timeout_err pulse together.
REQ-034: TIMEOUT=4, s_ready on 4th s_valid cycle -> normal completion with slave data, timeout_err stays 0.
REQ-035: resetn low for 1 cycle while in BUSY -> all outputs 0 next cycle, no ready pulse follows, next m0 request served normally.
